spi_master_tx: RTL
==================

// Module: spi_master_tx
// PURPOSE
//  SPI mode-0 transmitter (master): counterpart of the SPI receiver. Accepts one word over a
//  valid/ready handshake, frames it with cs_n, generates sclk internally from clk using a
//  half-period counter, and shifts the word out MSB-first on mosi. Used for loopback and test
//  stimulus towards the receiver.
// PARAMETERS
//  DATA_WIDTH  8     bits per frame (>=2)
//  DIV_COUNT   1020  half-period terminal count; one sclk half period = DIV_COUNT+1 clk cycles (>=0)
// PORTS
//  clk       in   1           system clock; all logic on posedge clk
//  rst       in   1           reset, synchronous, active-high
//  tx_data   in   DATA_WIDTH  word to send, sampled only on handshake
//  tx_valid  in   1           word available
//  tx_ready  out  1           block can accept a word (high only in IDLE)
//  sclk      out  1           SPI clock, idle low (CPOL=0)
//  mosi      out  1           serial data, changes on sclk falling edge, stable at rising edge
//  cs_n      out  1           chip select, active low, one assertion per word
//  done      out  1           1-cycle pulse when a frame completes (same cycle cs_n rises)
// BEHAVIOUR
//  - Reset (sync, on posedge clk with rst=1): state=IDLE, sclk=0, mosi=0, cs_n=1, done=0,
//    tx_ready=1, half-period counter=0, bit counter=0. Mid-frame reset aborts: no done pulse.
//  - Half-period tick: counter runs 0..DIV_COUNT in every state except IDLE; tick when
//    counter==DIV_COUNT, counter then wraps to 0. Counter width clog2(DIV_COUNT+1), min 1.
//  - All outputs registered. done defaults to 0 every cycle.
//  - States and transitions:
//    IDLE : tx_ready=1. On tx_valid&tx_ready: latch tx_data to shift reg, cs_n<=0,
//           mosi<=tx_data[DATA_WIDTH-1], bit_cnt<=0, counter<=0 -> LEAD. tx_ready low next cycle.
//    LEAD : on tick: sclk<=1 (bit 0 rising edge) -> HIGH.
//    HIGH : on tick: sclk<=0; if bit_cnt==DATA_WIDTH-1 -> TRAIL;
//           else bit_cnt++, mosi<=next bit (MSB-first) -> LOW.
//    LOW  : on tick: sclk<=1 -> HIGH.
//    TRAIL: on tick: cs_n<=1, done<=1, mosi<=0 -> GAP.
//    GAP  : on tick -> IDLE (guarantees cs_n high >= one half period between frames).
//  - Frame timing: cs_n low for exactly (2*DATA_WIDTH+1)*(DIV_COUNT+1) cycles; exactly
//    DATA_WIDTH rising sclk edges while cs_n low; sclk low whenever cs_n high.
//  - First rising edge is one half period after cs_n falls; mosi set with cs_n fall.
//  - tx_valid while not ready is ignored (no latch, no side effect); tx_data may change freely.
//  - Back-to-back: tx_valid held high -> next word accepted on first IDLE cycle after GAP.
//  - DIV_COUNT=0: tick every cycle; sclk = clk/2 during the frame.
// TESTING (DATA_WIDTH=8, DIV_COUNT=3 unless stated)
//  1. Send 0xA5 -> mosi at 8 sclk rising edges = 1,0,1,0,0,1,0,1; cs_n low 68 cycles;
//     one done pulse coincident with cs_n rise; sclk low in idle.
//  2. tx_valid held high with 0x3C then 0xFF -> two frames, correct bits, cs_n high >= 4 cycles
//     between frames, tx_ready low from cycle after accept until IDLE.
//  3. Pulse tx_valid during a frame with 0x00 -> ignored; frame in flight unchanged, one done.
//  4. Assert rst for 1 cycle after 3rd rising edge -> next cycle cs_n=1, sclk=0, mosi=0,
//     tx_ready=1, no done; a following 0x81 transfers correctly.
//  5. DIV_COUNT=0, send 0xC3 -> sclk toggles every clk, cs_n low 17 cycles, bits 1,1,0,0,0,0,1,1.
//  6. Send 0x00 and 0xFF -> mosi constant for whole frame, exactly 8 rising edges each.

Source files
------------

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: one word per valid/ready handshake, framed by cs_n,
// shifted out MSB-first with sclk derived from a half-period counter.
`timescale 1ns/1ps
module spi_master_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_COUNT  = 1020
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  done
);

  localparam int CW = (DIV_COUNT < 1) ? 1 : $clog2(DIV_COUNT + 1);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] TC   = CW'(DIV_COUNT);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
  // MSB goes straight to mosi on accept, so only the remaining bits are held
  logic [DATA_WIDTH-2:0] shreg, shreg_nxt;
  logic                  sclk_nxt, mosi_nxt, cs_n_nxt, done_nxt, ready_nxt;
  logic                  tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      done     <= 1'b0;
      tx_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      sclk     <= sclk_nxt;
      mosi     <= mosi_nxt;
      cs_n     <= cs_n_nxt;
      done     <= done_nxt;
      tx_ready <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    sclk_nxt    = sclk;
    mosi_nxt    = mosi;
    cs_n_nxt    = cs_n;
    done_nxt    = 1'b0;
    tick        = (cnt == TC);
    if (state == IDLE) cnt_nxt = '0;
    else               cnt_nxt = tick ? '0 : cnt + 1'b1;

    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          shreg_nxt   = tx_data[DATA_WIDTH-2:0];
          mosi_nxt    = tx_data[DATA_WIDTH-1];
          cs_n_nxt    = 1'b0;
          bit_cnt_nxt = '0;
          cnt_nxt     = '0;
          state_nxt   = LEAD;
        end
      end
      LEAD: begin
        if (tick) begin
          sclk_nxt  = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          sclk_nxt = 1'b0;
          if (bit_cnt == LAST) begin
            state_nxt = TRAIL;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            mosi_nxt    = shreg[DATA_WIDTH-2];
            shreg_nxt   = shreg << 1;
            state_nxt   = LOW;
          end
        end
      end
      LOW: begin
        if (tick) begin
          sclk_nxt  = 1'b1;
          state_nxt = HIGH;
        end
      end
      TRAIL: begin
        if (tick) begin
          cs_n_nxt  = 1'b1;
          done_nxt  = 1'b1;
          mosi_nxt  = 1'b0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    ready_nxt = (state_nxt == IDLE);
  end

endmodule
